// File: rtl/scoreboard_hazard_unit.sv
`default_nettype none
// ============================================================================
// scoreboard_hazard_unit - per-register countdown hazard scoreboard with
// mispredict flush, D-cache freeze and saturating perf counters.  Rev 1.0
// ============================================================================
module scoreboard_hazard_unit #(
  parameter int NUM_REGS   = 32,
  parameter int REG_W      = 5,
  parameter int MAX_LAT    = 4,
  parameter int ECALL_DIST = 2,
  parameter int CNT_W      = 32,
  localparam int LAT_W     = $clog2(MAX_LAT + 1),
  localparam int SB_W      = $clog2(MAX_LAT + ECALL_DIST)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_is_ecall,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_write,
  input  logic [LAT_W-1:0] id_lat,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target_pc,
  input  logic [1:0]       ex_bcond,
  input  logic             mem_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_nop,
  output logic             id_ex_nop,
  output logic             ex_pcsrc,
  output logic [31:0]      ex_correct_next_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0]      BCOND_NOT_TAKEN = 2'd0;
  localparam logic [1:0]      BCOND_TAKEN     = 2'd1;
  localparam logic [1:0]      BCOND_JUMP      = 2'd2;
  localparam logic [SB_W-1:0] DIST            = SB_W'(ECALL_DIST);

  logic [NUM_REGS-1:0][SB_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]              stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]              flush_count_q, flush_count_d;

  logic [SB_W-1:0] w_rs1_cnt, w_rs2_cnt, w_issue_val;
  logic            w_rs1_busy, w_rs2_busy, w_data_haz, w_mispredict, w_issue;
  logic [31:0]     w_pc_plus4, w_target;

  assign w_rs1_cnt  = cnt_q[id_rs1];
  assign w_rs2_cnt  = cnt_q[id_rs2];
  // Normal reads are satisfied by forwarding once the count reaches DIST;
  // an ecall reads in ID and must wait for the count to drain completely.
  assign w_rs1_busy = id_rs1_used && (id_rs1 != '0) &&
                      ((w_rs1_cnt > DIST) || (id_is_ecall && (w_rs1_cnt != '0)));
  assign w_rs2_busy = id_rs2_used && (id_rs2 != '0) &&
                      ((w_rs2_cnt > DIST) || (id_is_ecall && (w_rs2_cnt != '0)));
  assign w_data_haz = id_valid && (w_rs1_busy || w_rs2_busy);
  assign w_pc_plus4 = ex_pc + 32'd4;

  always_comb begin
    w_mispredict = 1'b0;
    w_target     = w_pc_plus4;
    case (ex_bcond)
      BCOND_TAKEN, BCOND_JUMP: begin
        w_mispredict = (id_pc != ex_target_pc);
        w_target     = ex_target_pc;
      end
      BCOND_NOT_TAKEN: w_mispredict = (id_pc != w_pc_plus4);
      default: ;
    endcase
  end

  always_comb begin
    pc_write           = 1'b1;
    if_id_write        = 1'b1;
    id_ex_write        = 1'b1;
    ex_mem_write       = 1'b1;
    if_id_nop          = 1'b0;
    id_ex_nop          = 1'b0;
    ex_pcsrc           = 1'b0;
    ex_correct_next_pc = w_pc_plus4;
    if (mem_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (w_mispredict) begin
      if_id_nop          = 1'b1;
      id_ex_nop          = 1'b1;
      ex_pcsrc           = 1'b1;
      ex_correct_next_pc = w_target;
    end else if (w_data_haz) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_nop   = 1'b1;
    end
  end

  assign w_issue     = id_valid && id_rd_write && (id_rd != '0) &&
                       !mem_stall && !w_mispredict && !w_data_haz;
  assign w_issue_val = SB_W'(id_lat) - SB_W'(1) + DIST;

  always_comb begin
    cnt_d = cnt_q;
    if (!mem_stall) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - SB_W'(1);
      end
    end
    // A fresh issue overwrites any pending count; in-order retire keeps WAW safe.
    if (w_issue) cnt_d[id_rd] = w_issue_val;
    cnt_d[0] = '0;

    stall_cycles_d = stall_cycles_q;
    if ((mem_stall || (!w_mispredict && w_data_haz)) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);

    flush_count_d = flush_count_q;
    if (!mem_stall && w_mispredict && (flush_count_q != '1))
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_scoreboard_hazard_unit - scoreboard-queue bench for the hazard unit.
// Rev 1.0
// ============================================================================
module tb_scoreboard_hazard_unit;

  localparam int NUM_REGS   = 32;
  localparam int REG_W      = 5;
  localparam int MAX_LAT    = 4;
  localparam int ECALL_DIST = 2;
  localparam int CNT_W      = 4;
  localparam int LAT_W      = $clog2(MAX_LAT + 1);
  localparam int MAXC       = (1 << CNT_W) - 1;

  localparam logic [1:0] BC_NT   = 2'd0;
  localparam logic [1:0] BC_T    = 2'd1;
  localparam logic [1:0] BC_J    = 2'd2;
  localparam logic [1:0] BC_NONE = 2'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid, id_rs1_used, id_rs2_used, id_is_ecall, id_rd_write;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic [LAT_W-1:0] id_lat;
  logic [31:0]      id_pc, ex_pc, ex_target_pc;
  logic [1:0]       ex_bcond;
  logic             mem_stall;
  logic             pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic             if_id_nop, id_ex_nop, ex_pcsrc;
  logic [31:0]      ex_correct_next_pc;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  scoreboard_hazard_unit #(
    .NUM_REGS(NUM_REGS), .REG_W(REG_W), .MAX_LAT(MAX_LAT),
    .ECALL_DIST(ECALL_DIST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_is_ecall(id_is_ecall), .id_rd(id_rd), .id_rd_write(id_rd_write),
    .id_lat(id_lat), .id_pc(id_pc), .ex_pc(ex_pc), .ex_target_pc(ex_target_pc),
    .ex_bcond(ex_bcond), .mem_stall(mem_stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_nop(if_id_nop), .id_ex_nop(id_ex_nop),
    .ex_pcsrc(ex_pcsrc), .ex_correct_next_pc(ex_correct_next_pc),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assert property (@(posedge clk) disable iff (reset)
    (id_valid && id_rd_write) |-> (id_lat >= 1 && id_lat <= MAX_LAT));

  typedef struct packed {
    logic [6:0]       ctrl;
    logic [31:0]      npc;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  exp_t       exp_q[$];
  int         mcnt[NUM_REGS];
  int         mstall, mflush;
  int         n_cmp, n_err;
  logic       obs_pc_write, obs_pcsrc;
  logic [6:0] obs_ctrl;
  logic [31:0] obs_npc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model of the scoreboard and priority rules
  function automatic bit m_busy(input logic used, input logic [REG_W-1:0] idx);
    if (!used || idx == 0) return 1'b0;
    if (mcnt[idx] > ECALL_DIST) return 1'b1;
    return id_is_ecall && (mcnt[idx] != 0);
  endfunction

  function automatic bit m_misp();
    if ((ex_bcond == BC_T || ex_bcond == BC_J) && id_pc != ex_target_pc) return 1'b1;
    if (ex_bcond == BC_NT && id_pc != ex_pc + 32'd4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_haz();
    return id_valid && (m_busy(id_rs1_used, id_rs1) || m_busy(id_rs2_used, id_rs2));
  endfunction

  function automatic exp_t m_expect();
    exp_t e;
    e.stall = CNT_W'(mstall);
    e.flush = CNT_W'(mflush);
    e.npc   = ex_pc + 32'd4;
    if (mem_stall)     e.ctrl = 7'b0000000;
    else if (m_misp()) begin
      e.ctrl = 7'b1111111;
      if (ex_bcond != BC_NT) e.npc = ex_target_pc;
    end
    else if (m_haz())  e.ctrl = 7'b0011010;
    else               e.ctrl = 7'b1111000;
    return e;
  endfunction

  task automatic m_update();
    bit misp, haz;
    if (reset) begin
      foreach (mcnt[r]) mcnt[r] = 0;
      mstall = 0;
      mflush = 0;
      return;
    end
    misp = m_misp();
    haz  = m_haz();
    if (!mem_stall) begin
      for (int r = 1; r < NUM_REGS; r++) if (mcnt[r] > 0) mcnt[r]--;
      if (id_valid && id_rd_write && id_rd != 0 && !misp && !haz)
        mcnt[id_rd] = int'(id_lat) - 1 + ECALL_DIST;
    end
    if ((mem_stall || (!misp && haz)) && mstall < MAXC) mstall++;
    if (!mem_stall && misp && mflush < MAXC) mflush++;
  endtask

  // One clock: push expectation, compare at negedge, advance model at posedge
  task automatic cycle();
    exp_t e;
    exp_q.push_back(m_expect());
    @(negedge clk);
    if (exp_q.size() == 0) check_eq("queue_empty", 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      check_eq("ctrl", {pc_write, if_id_write, id_ex_write, ex_mem_write,
                        if_id_nop, id_ex_nop, ex_pcsrc}, e.ctrl);
      check_eq("next_pc", ex_correct_next_pc, e.npc);
      check_eq("stall_cycles", stall_cycles, e.stall);
      check_eq("flush_count", flush_count, e.flush);
    end
    obs_pc_write = pc_write;
    obs_pcsrc    = ex_pcsrc;
    obs_npc      = ex_correct_next_pc;
    obs_ctrl     = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                    if_id_nop, id_ex_nop, ex_pcsrc};
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_is_ecall = 0; id_rd = 0; id_rd_write = 0; id_lat = 1;
    id_pc = 0; ex_pc = 0; ex_target_pc = 0; ex_bcond = BC_NONE; mem_stall = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  // Hold one instruction in ID until it leaves; returns the stall count
  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic ecall, input logic [4:0] rd,
                       input logic wr, input int lat, output int stalls);
    idle();
    id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_is_ecall = ecall; id_rd = rd; id_rd_write = wr; id_lat = LAT_W'(lat);
    stalls = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (obs_pc_write) break;
      stalls++;
    end
    if (!obs_pc_write) check_eq("issue_timeout", 32'd0, 32'd1);
    idle();
  endtask

  int st;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; mstall = 0; mflush = 0;
    foreach (mcnt[r]) mcnt[r] = 0;
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    cycle();
    check_eq("rst_stall", stall_cycles, 0);
    check_eq("rst_flush", flush_count, 0);

    // Load-use
    do_reset();
    issue(0, 0, 0, 0, 0, 5, 1, 2, st);  check_eq("load_issue", st, 0);
    issue(5, 1, 0, 0, 0, 6, 1, 1, st);  check_eq("load_use_stalls", st, 1);
    check_eq("load_use_cnt", stall_cycles, 1);

    // ecall after ALU / ALU dependent / ecall after load / longest latency
    do_reset();
    issue(0, 0, 0, 0, 0, 17, 1, 1, st);
    issue(17, 1, 0, 0, 1, 0, 0, 1, st); check_eq("ecall_alu_stalls", st, 2);
    issue(0, 0, 0, 0, 0, 9, 1, 1, st);
    issue(0, 0, 9, 1, 0, 3, 1, 1, st);  check_eq("alu_dep_stalls", st, 0);
    issue(0, 0, 0, 0, 0, 10, 1, 2, st);
    issue(10, 1, 0, 0, 1, 0, 0, 1, st); check_eq("ecall_load_stalls", st, 3);
    issue(0, 0, 0, 0, 0, 11, 1, 4, st);
    issue(0, 0, 11, 1, 0, 0, 0, 1, st); check_eq("lat4_dep_stalls", st, 3);

    // D-cache freeze holds the scoreboard
    do_reset();
    issue(0, 0, 0, 0, 0, 6, 1, 2, st);
    mem_stall = 1;
    repeat (3) cycle();
    mem_stall = 0;
    check_eq("freeze_cnt", stall_cycles, 3);
    issue(6, 1, 0, 0, 0, 0, 0, 1, st);  check_eq("freeze_held_stalls", st, 1);

    // Mispredict beats a simultaneous load-use hazard
    do_reset();
    issue(0, 0, 0, 0, 0, 5, 1, 2, st);
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1; id_rd = 7; id_rd_write = 1; id_lat = 1;
    id_pc = 32'h24; ex_pc = 32'h20; ex_target_pc = 32'h100; ex_bcond = BC_T;
    cycle();
    check_eq("misp_ctrl", obs_ctrl, 7'b1111111);
    check_eq("misp_target", obs_npc, 32'h100);
    check_eq("misp_flush", flush_count, 1);
    check_eq("misp_no_stall", stall_cycles, 0);
    issue(7, 1, 0, 0, 1, 0, 0, 1, st);  check_eq("flushed_no_issue", st, 0);

    // NOT_TAKEN and JUMP checks
    idle(); ex_bcond = BC_NT; ex_pc = 32'h40; id_pc = 32'h44;
    cycle();
    check_eq("nt_ok_pcsrc", obs_pcsrc, 0);
    check_eq("nt_ok_npc", obs_npc, 32'h44);
    id_pc = 32'h80;
    cycle();
    check_eq("nt_bad_pcsrc", obs_pcsrc, 1);
    check_eq("nt_bad_npc", obs_npc, 32'h44);
    ex_bcond = BC_J; ex_target_pc = 32'h200; id_pc = 32'h200;
    cycle();
    check_eq("jump_ok_pcsrc", obs_pcsrc, 0);
    idle();

    // Reset mid-operation, then x0 is never tracked
    do_reset();
    issue(0, 0, 0, 0, 0, 5, 1, 2, st);
    do_reset();
    check_eq("midrst_stall", stall_cycles, 0);
    check_eq("midrst_flush", flush_count, 0);
    issue(5, 1, 0, 0, 0, 0, 0, 1, st);  check_eq("midrst_dep_stalls", st, 0);
    issue(0, 0, 0, 0, 0, 0, 1, 4, st);
    issue(0, 1, 0, 1, 1, 0, 0, 1, st);  check_eq("x0_stalls", st, 0);

    // WAW: a short producer overwrites a long pending count
    do_reset();
    issue(0, 0, 0, 0, 0, 8, 1, 4, st);
    issue(0, 0, 0, 0, 0, 8, 1, 1, st);  check_eq("waw_issue", st, 0);
    issue(8, 1, 0, 0, 0, 0, 0, 1, st);  check_eq("waw_dep_stalls", st, 0);

    // Counter saturation
    do_reset();
    mem_stall = 1;
    repeat (MAXC + 5) cycle();
    mem_stall = 0;
    check_eq("stall_sat", stall_cycles, MAXC);
    ex_bcond = BC_T; ex_target_pc = 32'h100; id_pc = 32'h0;
    repeat (MAXC + 5) cycle();
    idle();
    check_eq("flush_sat", flush_count, MAXC);

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(49) == 0);
      id_valid    = ($urandom_range(7) != 0);
      id_rs1      = REG_W'($urandom_range(7));
      id_rs2      = REG_W'($urandom_range(7));
      id_rs1_used = $urandom_range(1);
      id_rs2_used = $urandom_range(1);
      id_is_ecall = ($urandom_range(7) == 0);
      id_rd       = REG_W'($urandom_range(7));
      id_rd_write = $urandom_range(1);
      id_lat      = LAT_W'($urandom_range(MAX_LAT, 1));
      ex_bcond    = 2'($urandom_range(3));
      ex_pc       = 32'h40;
      id_pc       = $urandom_range(1) ? 32'h44 : 32'h80;
      ex_target_pc = $urandom_range(1) ? 32'h44 : 32'h100;
      mem_stall   = ($urandom_range(4) == 0);
      cycle();
    end
    reset = 0;
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
Parametrised successor to the single-distance hazard detector. It sits beside the ID stage and replaces fixed EX/MEM rd comparisons with a per-register countdown scoreboard. This lets the pipeline carry variable-latency producers (ALU, load, multi-cycle units) without new comparator logic. It also arbitrates branch/jump mispredict flushes and data-cache freeze, and keeps saturating stall and flush performance counters.

Parameters:
NUM_REGS, 32, architectural registers tracked; index 0 is never tracked
REG_W, 5, register index width
MAX_LAT, 4, largest legal id_lat value
ECALL_DIST, 2, extra cycles an ID-stage (non-forwarded) read waits beyond the forwarding point
CNT_W, 32, perf counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction (0 = bubble)
id_rs1, id_rs2  in  REG_W  source indices
id_rs1_used, id_rs2_used  in  1  source actually read
id_is_ecall  in  1  ID instruction reads its source in ID (no forwarding)
id_rd  in  REG_W  destination index
id_rd_write  in  1  instruction writes id_rd
id_lat  in  clog2(MAX_LAT+1)  producer latency, 1..MAX_LAT (1 = ALU, 2 = load)
id_pc, ex_pc, ex_target_pc  in  32  PCs for mispredict check
ex_bcond  in  2  BCOND_NOT_TAKEN / BCOND_TAKEN / BCOND_JUMP / none (opcodes.v encodings)
mem_stall  in  1  D-cache not ready/valid/hit for current MEM access
pc_write, if_id_write, id_ex_write, ex_mem_write  out  1  pipeline register enables
if_id_nop, id_ex_nop  out  1  insert bubble
ex_pcsrc  out  1  select ex_correct_next_pc over predictor
ex_correct_next_pc  out  32  redirect target
stall_cycles, flush_count  out  CNT_W  perf counters

Behaviour:
- State: cnt[1..NUM_REGS-1], each clog2(MAX_LAT+ECALL_DIST) bits wide, plus two perf counters. Reset clears all of them. The reset takes effect on the next clk edge, mid-operation included.
- Issue value: V = id_lat - 1 + ECALL_DIST.
- Source check, per source: src_busy = used && idx != 0 && cnt[idx] > ECALL_DIST. ecall_busy = id_is_ecall && used && idx != 0 && cnt[idx] != 0.
- data_haz = id_valid && (any src_busy || any ecall_busy).
- mispredict:
  - TAKEN or JUMP with id_pc != ex_target_pc: target = ex_target_pc.
  - NOT_TAKEN with id_pc != ex_pc+4: target = ex_pc+4.
- Output priority (combinational from state and inputs):
  1. mem_stall: all four write enables = 0, nops = 0, ex_pcsrc = 0.
  2. mispredict: if_id_nop = id_ex_nop = 1, ex_pcsrc = 1, ex_correct_next_pc = target, all enables = 1.
  3. data_haz: pc_write = if_id_write = 0, id_ex_nop = 1.
  4. Otherwise: all enables = 1, nops = 0, ex_pcsrc = 0.
  - ex_correct_next_pc defaults to ex_pc+4 whenever ex_pcsrc = 0.
- Scoreboard update each edge:
  - mem_stall = 1: all cnt hold.
  - Otherwise every nonzero cnt decrements by 1.
  - Issue occurs when id_valid && id_rd_write && id_rd != 0 && none of (mem_stall, mispredict, data_haz). On issue, cnt[id_rd] <= V, overriding the decrement.
  - A flushed ID instruction never issues, so no rollback is needed.
- Resulting timing with ECALL_DIST = 2:
  - ALU dependent: no stall.
  - Load dependent: 1 stall.
  - ecall after ALU: 2 stalls.
  - ecall after load: 3 stalls.
- Same rd reissued while pending: the new V overwrites the old count (WAW safe because the pipeline is in-order).
- Perf counters:
  - stall_cycles += 1 when mem_stall, or when data_haz is the selected action.
  - flush_count += 1 per mispredict cycle, but not when mem_stall masks it.
  - Both saturate at all-ones.
- id_lat = 0 or id_lat > MAX_LAT is illegal; behaviour is undefined. Verification asserts against it.

Test Plan:
- Load x5 (id_lat=2), next cycle add reading x5 -> one cycle with pc_write=0, id_ex_nop=1; following cycle no stall; stall_cycles=1.
- ALU write x17 (id_lat=1), then ecall reading x17 -> 2 stall cycles, then proceeds; an ALU-only dependent shows 0 stalls.
- mem_stall held 3 cycles while load x6 is pending (cnt=3) -> all enables 0 for 3 cycles; cnt[x6] still 3 after the freeze; stall_cycles=3.
- ex_bcond=TAKEN, ex_target_pc=0x100, id_pc=0x24, with a simultaneous load-use hazard in ID -> if_id_nop=id_ex_nop=1, ex_pcsrc=1, target 0x100; no issue; flush_count=1.
- ex_bcond=NOT_TAKEN, ex_pc=0x40, id_pc=0x44 -> no flush; with id_pc=0x80 -> redirect to 0x44.
- Reset asserted with cnt[x5]=3 -> next cycle cnt cleared, perf counters 0, a dependent on x5 does not stall; also write x0 (id_lat=4) then read x0 -> never stalls.
